// File: rtl/cc_pkg.sv
// Shared cache-controller definitions: AXI read-burst attributes for one
// cache line, miss-request FSM states and the address type.
package cc_pkg;

  localparam int         CC_LINE_BEATS     = 8;
  localparam logic [3:0] CC_AXI_LEN_LINE   = 4'(CC_LINE_BEATS - 1);
  localparam logic [2:0] CC_AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] CC_AXI_BURST_WRAP = 2'b10;

  typedef enum logic {S_IDLE, S_AR} cc_mreq_state_t;

  typedef logic [31:0] cc_addr_t;

  // Clear the byte offset within a 64-bit beat; the WRAP burst then starts
  // on the critical word and wraps around the line.
  function automatic cc_addr_t cc_beat_align(input cc_addr_t addr);
    return {addr[31:3], 3'b000};
  endfunction

endpackage

// File: rtl/cc_miss_addr_fifo.sv
// Show-ahead miss-address FIFO. The head entry is always visible on rdata;
// a pop on an empty FIFO is ignored. Push and pop may coincide at any
// occupancy, including full, in which case the count is unchanged.
module cc_miss_addr_fifo #(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = 32,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wren,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rden,
  output logic              full,
  output logic              empty,
  output logic [PTR_W:0]    count,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [PTR_W:0]    cnt;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt == (PTR_W+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rptr];
  assign do_pop  = rden & ~empty;
  assign do_push = wren & (~full | do_pop);

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + PTR_W'(1);
      end
      if (do_pop) rptr <= rptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (PTR_W+1)'(1);
        2'b01:   cnt <= cnt - (PTR_W+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // The fill stage should never pop an empty FIFO.
  assert property (@(posedge clk) disable iff (rst) !(rden && empty));

endmodule

// File: rtl/cc_miss_request_unit.sv
// Miss request unit: accepts line misses, issues one critical-word-first
// WRAP AR burst per miss and queues the miss address for the fill stage.
// A request is only accepted while a FIFO slot is free, so the push that
// follows the AR handshake can never overflow.
module cc_miss_request_unit
  import cc_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] AR_ID      = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_req_valid_i,
  input  logic [31:0] miss_req_addr_i,
  output logic        miss_req_ready_o,
  output logic [3:0]  mem_arid_o,
  output logic [31:0] mem_araddr_o,
  output logic [3:0]  mem_arlen_o,
  output logic [2:0]  mem_arsize_o,
  output logic [1:0]  mem_arburst_o,
  output logic        mem_arvalid_o,
  input  logic        mem_arready_i,
  output logic        miss_addr_fifo_empty_o,
  output logic [31:0] miss_addr_fifo_rdata_o,
  input  logic        miss_addr_fifo_rden_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  cc_mreq_state_t  state_q;
  cc_mreq_state_t  state_d;
  cc_addr_t        addr_q;
  logic            accept;
  logic            fifo_push;
  logic            fifo_full;
  logic [PTR_W:0]  fifo_count;

  assign accept        = miss_req_valid_i & miss_req_ready_o;
  assign mem_arid_o    = AR_ID;
  assign mem_araddr_o  = cc_beat_align(addr_q);
  assign mem_arlen_o   = CC_AXI_LEN_LINE;
  assign mem_arsize_o  = CC_AXI_SIZE_8B;
  assign mem_arburst_o = CC_AXI_BURST_WRAP;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and outputs: ready depends only on registered state and
  // registered occupancy, never on valid or on a same-cycle pop.
  always_comb begin
    state_d          = state_q;
    miss_req_ready_o = 1'b0;
    mem_arvalid_o    = 1'b0;
    fifo_push        = 1'b0;
    case (state_q)
      S_IDLE: begin
        miss_req_ready_o = ~fifo_full;
        if (miss_req_valid_i && !fifo_full) state_d = S_AR;
      end
      S_AR: begin
        mem_arvalid_o = 1'b1;
        if (mem_arready_i) begin
          fifo_push = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Miss address is captured at accept and held stable through the AR phase.
  always_ff @(posedge clk) begin
    if (rst)         addr_q <= '0;
    else if (accept) addr_q <= miss_req_addr_i;
  end

  cc_miss_addr_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wren  (fifo_push),
    .wdata (addr_q),
    .rden  (miss_addr_fifo_rden_i),
    .full  (fifo_full),
    .empty (miss_addr_fifo_empty_o),
    .count (fifo_count),
    .rdata (miss_addr_fifo_rdata_o)
  );

  // Occupancy can never exceed the number of slots.
  assert property (@(posedge clk) disable iff (rst) 32'(fifo_count) <= FIFO_DEPTH);

endmodule

// File: tb/tb_cc_miss_request_unit.sv
// Directed bench for cc_miss_request_unit: a vector table of miss/pop pairs
// plus hand-written sequences for backpressure, full FIFO and reset.
module tb_cc_miss_request_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_valid;
  logic [31:0] miss_addr;
  logic        miss_ready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic        fifo_empty;
  logic [31:0] fifo_rdata;
  logic        fifo_rden;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] addr;
    int          delay;
    logic [31:0] exp_araddr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  cc_miss_request_unit #(.FIFO_DEPTH(4), .AR_ID(4'd0)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .miss_req_valid_i       (miss_valid),
    .miss_req_addr_i        (miss_addr),
    .miss_req_ready_o       (miss_ready),
    .mem_arid_o             (arid),
    .mem_araddr_o           (araddr),
    .mem_arlen_o            (arlen),
    .mem_arsize_o           (arsize),
    .mem_arburst_o          (arburst),
    .mem_arvalid_o          (arvalid),
    .mem_arready_i          (arready),
    .miss_addr_fifo_empty_o (fifo_empty),
    .miss_addr_fifo_rdata_o (fifo_rdata),
    .miss_addr_fifo_rden_i  (fifo_rden)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one request, wait (bounded) for acceptance, check the AR phase
  // through 'delay' stalled cycles, then complete the handshake.
  task automatic issue(input logic [31:0] a, input int delay, input logic [31:0] exp_ar);
    int w = 0;
    miss_valid = 1'b1;
    miss_addr  = a;
    while (!miss_ready && w < 20) begin
      step();
      w++;
    end
    check("accept_ready", 32'(miss_ready), 32'd1);
    step();
    miss_valid = 1'b0;
    check("arvalid_up", 32'(arvalid), 32'd1);
    check("araddr", araddr, exp_ar);
    check("arlen", 32'(arlen), 32'd7);
    check("arsize", 32'(arsize), 32'd3);
    check("arburst", 32'(arburst), 32'd2);
    check("arid", 32'(arid), 32'd0);
    for (int i = 0; i < delay; i++) begin
      step();
      check("stall_arvalid", 32'(arvalid), 32'd1);
      check("stall_araddr", araddr, exp_ar);
      check("stall_ready", 32'(miss_ready), 32'd0);
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    check("arvalid_down", 32'(arvalid), 32'd0);
  endtask

  task automatic pop();
    fifo_rden = 1'b1;
    step();
    fifo_rden = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h0000_1238, 0, 32'h0000_1238, 32'h0000_1238};
    vecs[1] = '{32'hDEAD_BEEF, 1, 32'hDEAD_BEE8, 32'hDEAD_BEEF};
    vecs[2] = '{32'h8000_0007, 0, 32'h8000_0000, 32'h8000_0007};
    vecs[3] = '{32'hFFFF_FFFC, 2, 32'hFFFF_FFF8, 32'hFFFF_FFFC};
    vecs[4] = '{32'h0000_0000, 0, 32'h0000_0000, 32'h0000_0000};
    vecs[5] = '{32'h1234_5675, 0, 32'h1234_5670, 32'h1234_5675};
    vecs[6] = '{32'h0000_0041, 3, 32'h0000_0040, 32'h0000_0041};
    vecs[7] = '{32'hCAFE_F00D, 0, 32'hCAFE_F008, 32'hCAFE_F00D};
    vecs[8] = '{32'h7FFF_FFFF, 1, 32'h7FFF_FFF8, 32'h7FFF_FFFF};
    vecs[9] = '{32'h0BAD_C0DE, 0, 32'h0BAD_C0D8, 32'h0BAD_C0DE};

    rst        = 1'b1;
    miss_valid = 1'b0;
    miss_addr  = '0;
    arready    = 1'b0;
    fifo_rden  = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_ready", 32'(miss_ready), 32'd1);
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_araddr", araddr, 32'h0);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_rdata", fifo_rdata, 32'h0);

    // Single miss with arready high
    issue(32'h0000_1238, 0, 32'h0000_1238);
    check("single_empty", 32'(fifo_empty), 32'd0);
    check("single_rdata", fifo_rdata, 32'h0000_1238);
    check("single_ready", 32'(miss_ready), 32'd1);
    pop();
    check("single_pop_empty", 32'(fifo_empty), 32'd1);

    // AR backpressure for 5 cycles: nothing pushed until the handshake
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_2000;
    step();
    miss_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_arvalid", 32'(arvalid), 32'd1);
      check("bp_araddr", araddr, 32'h0000_2000);
      check("bp_ready", 32'(miss_ready), 32'd0);
      check("bp_empty", 32'(fifo_empty), 32'd1);
      step();
    end
    check("bp_arvalid_end", 32'(arvalid), 32'd1);
    arready = 1'b1;
    step();
    arready = 1'b0;
    check("bp_arvalid_down", 32'(arvalid), 32'd0);
    check("bp_push_empty", 32'(fifo_empty), 32'd0);
    check("bp_rdata", fifo_rdata, 32'h0000_2000);
    pop();
    check("bp_pop_empty", 32'(fifo_empty), 32'd1);

    // Fill to four outstanding, fifth request must wait for a pop
    issue(32'h0000_0100, 0, 32'h0000_0100);
    issue(32'h0000_0140, 0, 32'h0000_0140);
    issue(32'h0000_0180, 0, 32'h0000_0180);
    issue(32'h0000_01C0, 0, 32'h0000_01C0);
    check("full_ready", 32'(miss_ready), 32'd0);
    check("full_head", fifo_rdata, 32'h0000_0100);
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_0200;
    step();
    step();
    check("full_hold_ready", 32'(miss_ready), 32'd0);
    check("full_hold_arvalid", 32'(arvalid), 32'd0);
    pop();
    check("after_pop_ready", 32'(miss_ready), 32'd1);
    check("after_pop_arvalid", 32'(arvalid), 32'd0);
    check("after_pop_head", fifo_rdata, 32'h0000_0140);
    step();
    miss_valid = 1'b0;
    check("fifth_arvalid", 32'(arvalid), 32'd1);
    check("fifth_araddr", araddr, 32'h0000_0200);

    // Push (AR handshake) and pop on the same edge
    arready   = 1'b1;
    fifo_rden = 1'b1;
    step();
    arready   = 1'b0;
    fifo_rden = 1'b0;
    check("pp_arvalid", 32'(arvalid), 32'd0);
    check("pp_head", fifo_rdata, 32'h0000_0180);
    check("pp_ready", 32'(miss_ready), 32'd1);
    issue(32'h0000_0240, 0, 32'h0000_0240);
    check("refull_ready", 32'(miss_ready), 32'd0);
    check("order0", fifo_rdata, 32'h0000_0180);
    pop();
    check("order1", fifo_rdata, 32'h0000_01C0);
    pop();
    check("order2", fifo_rdata, 32'h0000_0200);
    pop();
    check("order3", fifo_rdata, 32'h0000_0240);
    check("order3_empty", 32'(fifo_empty), 32'd0);
    pop();
    check("drain_empty", 32'(fifo_empty), 32'd1);
    check("drain_ready", 32'(miss_ready), 32'd1);

    // Table: sequential miss/pop pairs across pointer wrap
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].addr, vecs[i].delay, vecs[i].exp_araddr);
      check("vec_empty", 32'(fifo_empty), 32'd0);
      check("vec_rdata", fifo_rdata, vecs[i].exp_rdata);
      pop();
      check("vec_pop_empty", 32'(fifo_empty), 32'd1);
    end

    // Reset while an AR is pending with two entries queued
    issue(32'h0000_0300, 0, 32'h0000_0300);
    issue(32'h0000_0340, 0, 32'h0000_0340);
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_0380;
    step();
    miss_valid = 1'b0;
    check("pre_rst_arvalid", 32'(arvalid), 32'd1);
    check("pre_rst_head", fifo_rdata, 32'h0000_0300);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_arvalid", 32'(arvalid), 32'd0);
    check("mid_rst_empty", 32'(fifo_empty), 32'd1);
    check("mid_rst_ready", 32'(miss_ready), 32'd1);
    check("mid_rst_rdata", fifo_rdata, 32'h0);
    check("mid_rst_araddr", araddr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
